// File: rtl/peripheral_ram_controller.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_ram_controller
// Brief    : Valid/ready request front end for a single-port synchronous RAM
//            with an in-order, credit-protected read response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_ram_controller #(
    parameter int AW        = 10,
    parameter int DW        = 16,
    parameter int RSP_DEPTH = 4
) (
    input  logic                ram_clk,
    input  logic                ram_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [AW-1:0]       req_addr,
    input  logic [DW-1:0]       req_wdata,
    input  logic [DW/8-1:0]     req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DW-1:0]       rsp_rdata,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_din,
    output logic                ram_cen,
    output logic [DW/8-1:0]     ram_wen,
    input  logic [DW-1:0]       ram_dout
);

    localparam int c_bw = DW / 8;
    localparam int c_ow = $clog2(RSP_DEPTH + 1);
    localparam int c_pw = $clog2(RSP_DEPTH);
    localparam logic [c_ow-1:0] c_depth = c_ow'(RSP_DEPTH);
    localparam logic [c_pw-1:0] c_last  = c_pw'(RSP_DEPTH - 1);

    logic [c_ow-1:0] r_outst;
    logic            r_cen;
    logic [c_bw-1:0] r_wen;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_din;
    logic            r_rd_acc;
    logic            r_rd_pend;
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_ow-1:0] r_count;
    logic [DW-1:0]   r_mem [0:RSP_DEPTH-1];

    logic w_accept;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_push;
    logic w_pop;

    // Credit check only: every accepted read is guaranteed a FIFO slot.
    assign req_ready = !ram_rst && (r_outst < c_depth);
    assign w_accept  = req_valid && req_ready;
    assign w_rd_acc  = w_accept && !req_write;
    assign w_wr_acc  = w_accept && req_write && (req_be != '0);
    assign w_push    = r_rd_pend;
    assign w_pop     = rsp_valid && rsp_ready;

    assign rsp_valid = (r_count != '0);
    assign rsp_rdata = rsp_valid ? r_mem[r_rd_ptr] : '0;

    assign ram_cen  = r_cen;
    assign ram_wen  = r_wen;
    assign ram_addr = r_addr;
    assign ram_din  = r_din;

    // Command stage: every RAM-facing output is a flop.
    always_ff @(posedge ram_clk or posedge ram_rst) begin
        if (ram_rst) begin
            r_cen     <= 1'b1;
            r_wen     <= '1;
            r_addr    <= '0;
            r_din     <= '0;
            r_rd_acc  <= 1'b0;
            r_rd_pend <= 1'b0;
        end else begin
            r_cen     <= !(w_rd_acc || w_wr_acc);
            r_wen     <= w_wr_acc ? ~req_be : '1;
            r_rd_acc  <= w_rd_acc;
            r_rd_pend <= r_rd_acc;
            if (w_rd_acc || w_wr_acc) begin
                r_addr <= req_addr;
            end
            if (w_wr_acc) begin
                r_din <= req_wdata;
            end
        end
    end

    always_ff @(posedge ram_clk or posedge ram_rst) begin
        if (ram_rst) begin
            r_outst <= '0;
        end else if (w_rd_acc && !w_pop) begin
            r_outst <= r_outst + 1'b1;
        end else if (!w_rd_acc && w_pop) begin
            r_outst <= r_outst - 1'b1;
        end
    end

    // Response FIFO pointers and occupancy; storage itself needs no reset.
    always_ff @(posedge ram_clk or posedge ram_rst) begin
        if (ram_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge ram_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ram_dout;
        end
    end

    a_rsp_no_overflow: assert property (
        @(posedge ram_clk) disable iff (ram_rst) w_push |-> (r_count != c_depth));

endmodule
`default_nettype wire

// File: tb/tb_peripheral_ram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_ram_controller
// Brief    : Randomized self-checking bench with a RAM model and a
//            transaction-level reference model of the controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_ram_controller;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 4;

    logic          ram_clk = 1'b0;
    logic          ram_rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [BW-1:0] req_be = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_cen;
    logic [BW-1:0] ram_wen;
    logic [DW-1:0] ram_dout = '0;

    peripheral_ram_controller #(.AW(AW), .DW(DW), .RSP_DEPTH(DEPTH)) u_dut (
        .ram_clk   (ram_clk),
        .ram_rst   (ram_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_cen   (ram_cen),
        .ram_wen   (ram_wen),
        .ram_dout  (ram_dout)
    );

    always #5 ram_clk = ~ram_clk;

    // Single-port synchronous RAM with byte write enables.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge ram_clk) begin
        if (!ram_cen) begin
            for (int b = 0; b < BW; b++) begin
                if (!ram_wen[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            end
            ram_dout <= ram_mem[ram_addr];
        end
    end

    // Reference model state
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } rsp_t;

    logic [DW-1:0] shadow [0:(1<<AW)-1];
    rsp_t          q[$];
    int            s = 0;
    int            m_outst = 0;
    logic          e_cen = 1'b1;
    logic [BW-1:0] e_wen = '1;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_din = '0;
    logic          e_wr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d, t=%0t)", tag, obs, exp, s, $time);
        end
    endtask

    // One clock: check outputs for this cycle, drive inputs, advance the model.
    task automatic cycle(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be,
                         input logic rr);
        logic mv;
        logic acc;
        mv = (q.size() > 0) && (q[0].t <= s);
        check_eq("req_ready", req_ready, m_outst < DEPTH);
        check_eq("rsp_valid", rsp_valid, mv);
        if (mv) check_eq("rsp_rdata", rsp_rdata, q[0].d);
        check_eq("ram_cen", ram_cen, e_cen);
        check_eq("ram_wen", ram_wen, e_wen);
        if (!e_cen) check_eq("ram_addr", ram_addr, e_addr);
        if (e_wr) check_eq("ram_din", ram_din, e_din);

        req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        rsp_ready = rr;

        acc = v && (m_outst < DEPTH);
        if (mv && rr) begin
            void'(q.pop_front());
            m_outst--;
        end
        e_cen = 1'b1; e_wen = '1; e_wr = 1'b0;
        if (acc && !w) begin
            q.push_back('{d: shadow[a], t: s + 3});
            m_outst++;
            e_cen = 1'b0; e_addr = a;
        end else if (acc && (be != '0)) begin
            for (int b = 0; b < BW; b++) if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
            e_cen = 1'b0; e_wen = ~be; e_addr = a; e_din = d; e_wr = 1'b1;
        end
        s++;
        @(negedge ram_clk);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic rr);
        cycle(1'b1, 1'b0, a, '0, '0, rr);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be, input logic rr);
        cycle(1'b1, 1'b1, a, d, be, rr);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, rr);
    endtask

    task automatic rand_inputs();
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
        req_be    = BW'($urandom);
        rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cen"}, ram_cen, 1'b1);
        check_eq({tag, "_wen"}, ram_wen, {BW{1'b1}});
        check_eq({tag, "_addr"}, ram_addr, '0);
        check_eq({tag, "_din"}, ram_din, '0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, '0);
        check_eq({tag, "_req_ready"}, req_ready, 1'b0);
    endtask

    // Asynchronous assertion mid-cycle, n further cycles, release at a falling edge.
    task automatic do_reset(input int n);
        ram_rst = 1'b1;
        rand_inputs();
        #1;
        check_reset_outputs("rst_assert");
        for (int i = 0; i < n; i++) begin
            @(negedge ram_clk);
            rand_inputs();
            #1;
            check_reset_outputs("rst_hold");
        end
        @(negedge ram_clk);
        ram_rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        q.delete();
        m_outst = 0; e_cen = 1'b1; e_wen = '1; e_wr = 1'b0;
        #1;
        check_eq("rst_release_ready", req_ready, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_err=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge ram_clk);
        do_reset(3);

        // Write then read of the same address on the next cycle
        wr(10'h005, 16'hA55A, 2'b11, 1'b1);
        rd(10'h005, 1'b1);
        idle(4, 1'b1);

        // Byte lanes, including a zero-enable write that must not touch the RAM
        wr(10'h010, 16'h1234, 2'b11, 1'b1);
        wr(10'h010, 16'hFFFF, 2'b10, 1'b1);
        wr(10'h010, 16'h0000, 2'b00, 1'b1);
        rd(10'h010, 1'b1);
        idle(4, 1'b1);

        // Backpressure: five reads with responses stalled
        for (int i = 0; i < 5; i++) wr(AW'(i), DW'(16'h1100 + i * 16'h0111), 2'b11, 1'b1);
        idle(2, 1'b1);
        for (int i = 0; i < 4; i++) rd(AW'(i), 1'b0);
        for (int i = 0; i < 6; i++) rd(10'h004, 1'b0);
        for (int i = 0; i < 3; i++) rd(10'h004, 1'b1);
        idle(6, 1'b1);

        // Full throughput
        for (int i = 0; i < 16; i++) rd(AW'(i), 1'b1);
        idle(5, 1'b1);

        // Reset with reads in flight
        for (int i = 0; i < 3; i++) rd(AW'(i), 1'b0);
        idle(1, 1'b0);
        do_reset(1);
        idle(5, 1'b1);
        rd(10'h005, 1'b1);
        idle(4, 1'b1);

        // Randomized mix over a small address window to force collisions
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)), DW'($urandom), BW'($urandom),
                  ($urandom_range(0, 3) != 0));
        end
        idle(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/peripheral_ram_controller.md
# peripheral_ram_controller

Request/response front end for the single-port peripheral RAM. It accepts word-addressed read and write requests on a valid/ready port and drives the RAM's chip enable, write enables, address and write data, one operation per cycle. It captures the synchronous RAM read data into an in-order response FIFO with credit-based backpressure. It sits directly upstream of the RAM and owns the complete RAM port (`ram_addr`, `ram_din`, `ram_cen`, `ram_wen`, `ram_dout`).

## Interface
Parameters:
- `AW`, 10: RAM word-address width.
- `DW`, 16: data width; must be a multiple of 8; `BW = DW/8` byte lanes.
- `RSP_DEPTH`, 4: response FIFO depth; also the maximum number of outstanding reads; must be at least 4.

Ports:
- `ram_clk`  in  1  clock; the only clock.
- `ram_rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request ready.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  word address.
- `req_wdata`  in  DW  write data.
- `req_be`  in  BW  byte enables, active-high; ignored for reads.
- `rsp_valid`  out  1  read response valid.
- `rsp_ready`  in  1  read response accepted.
- `rsp_rdata`  out  DW  read data.
- `ram_addr`  out  AW  RAM address.
- `ram_din`  out  DW  RAM write data.
- `ram_cen`  out  1  RAM chip enable, low active.
- `ram_wen`  out  BW  RAM byte write enables, low active.
- `ram_dout`  in  DW  RAM read data, valid the cycle after the access cycle.

## Operation
**Handshakes**
- Request accept: `req_valid && req_ready` at a rising edge.
- Response pop: `rsp_valid && rsp_ready` at a rising edge.

**Credit counter `outst`**
- Width: `$clog2(RSP_DEPTH+1)`.
- Counts accepted reads not yet popped.
- +1 on read accept; -1 on pop; unchanged when both occur in the same cycle.
- `req_ready = !ram_rst && (outst < RSP_DEPTH)`. It is combinational on `outst` and never depends on `req_valid`.
- Writes do not consume credit, but are blocked whenever `req_ready` = 0.

**Command stage (registered RAM outputs)**
- Read accept:
  - next cycle `ram_cen=0`, `ram_wen` all ones, `ram_addr=req_addr`.
  - `rd_pend` is set for the following cycle.
- Write accept with `req_be != 0`:
  - next cycle `ram_cen=0`, `ram_wen=~req_be`, `ram_addr=req_addr`, `ram_din=req_wdata`.
- Write accept with `req_be == 0`:
  - request is consumed; no RAM access (`ram_cen` stays 1); no response.
- No accept:
  - `ram_cen=1`, `ram_wen` all ones.
  - `ram_addr` and `ram_din` hold their last values.

**Capture stage**
- When `rd_pend` = 1, `ram_dout` is written into the FIFO at the end of that cycle.
- The credit limit guarantees the FIFO never overflows. The design must still assert (simulation only) that no push occurs while the FIFO is full.

**Response FIFO**
- `RSP_DEPTH` entries, in order, with registered read and write pointers that wrap modulo `RSP_DEPTH`.
- `rsp_valid` = FIFO not empty.
- `rsp_rdata` = head entry. It is held stable while `rsp_valid && !rsp_ready`.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- Push into an empty FIFO makes the data visible the next cycle. There is no bypass.

**Ordering**
- RAM operations are issued strictly in accept order.
- A read accepted the cycle after a write to the same address returns the new data.

**Reset**
- Asynchronous assertion, at any time, clears:
  - `outst` and both FIFO pointers;
  - `rd_pend`;
  - all in-flight requests and responses.
- Output values during and after reset: `ram_cen=1`, `ram_wen` all ones, `ram_addr=0`, `ram_din=0`, `rsp_valid=0`, `rsp_rdata=0`, `req_ready=0`.
- `req_ready` rises in the first cycle after deassertion.

## Timing
- Read accepted at edge of cycle N:
  - N+1: RAM access (`ram_cen` low).
  - N+2: `ram_dout` captured.
  - N+3: `rsp_valid`=1 (latency 3).
- Write accepted at N: RAM write occurs in N+1.
- Throughput is one request per cycle when `rsp_ready` is held at 1. Steady-state `outst` is at most 3, so `RSP_DEPTH` ≥ 4 never stalls.
- With `rsp_ready`=0: after `RSP_DEPTH` read accepts, `req_ready` falls in the following cycle. It rises again the cycle after the first pop.
- The RAM interface sees no combinational paths from `req_*`; every RAM output is a flop.

## Test plan
- **Reset values:** assert `ram_rst` for 3 cycles with random inputs -> `ram_cen=1`, `ram_wen=2'b11`, `ram_addr=0`, `ram_din=0`, `rsp_valid=0`, `req_ready=0`; `req_ready=1` on the first cycle after release.
- **Write then read:** write `addr 0x005`, `data 0xA55A`, `be=2'b11`, then read `0x005` next cycle -> `ram_wen=2'b00` in N+1; `rsp_rdata=0xA55A`, `rsp_valid` at read accept +3.
- **Byte lanes:** write `0x1234` to `0x010`, then write `0xFFFF` with `be=2'b10`, then write with `be=2'b00` -> second write drives `ram_wen=2'b01`; third write keeps `ram_cen` high; read returns `0xFF34`.
- **Backpressure:** `rsp_ready=0`, issue 5 back-to-back reads of `0x000` to `0x004` -> 4 accepted, `req_ready` low until `rsp_ready=1`; responses popped in address order with no data change while stalled.
- **Full throughput:** `rsp_ready=1`, 16 consecutive reads -> `req_ready` never drops; one response per cycle; simultaneous accept and pop leave `outst` unchanged.
- **Reset mid-operation:** assert `ram_rst` with 3 reads in flight -> `rsp_valid=0` immediately; no stale responses after release; the next read returns correct data.
